// File: rtl/servo_frame_sched.sv
// servo_frame_sched: shared PWM frame counter and commit scheduler for the
// left/right servo comparators.
// Ports: clk, rst (sync, active-high); upd_valid/upd_ready/upd_ch/upd_data
// update handshake from SPI; cntr_val frame tick counter; x_left/x_right
// committed compare values; frame_start wrap pulse; timeout neutral fallback.
module servo_frame_sched #(
    parameter int TICK_DIV       = 100,
    parameter int PERIOD         = 3000,
    parameter int X_OFFSET       = 1000,
    parameter int RAW_MAX        = 1000,
    parameter int NEUTRAL        = 1500,
    parameter int MAX_STEP       = 50,
    parameter int TIMEOUT_FRAMES = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic        upd_ch,
    input  logic [9:0]  upd_data,
    output logic [11:0] cntr_val,
    output logic [10:0] x_left,
    output logic [10:0] x_right,
    output logic        frame_start,
    output logic        timeout
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT_FRAMES + 1);

    typedef enum logic [1:0] {
        S_RESET,
        S_RUN,
        S_COMMIT
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [11:0]     cntr_q, cntr_d;
    logic [10:0]     xl_q, xl_d;
    logic [10:0]     xr_q, xr_d;
    logic [10:0]     shl_q, shl_d;
    logic [10:0]     shr_q, shr_d;
    logic            fs_q, fs_d;
    logic            to_q, to_d;
    logic [TW-1:0]   tocnt_q, tocnt_d;
    logic            fresh_q, fresh_d;

    logic            tick;
    logic            wrap;
    logic            xfer;
    logic [9:0]      raw_sat;
    logic [10:0]     tgt;
    logic [TW-1:0]   tocnt_inc;
    logic [10:0]     tl;
    logic [10:0]     tr;

    // Slew limiter, evaluated in 12 bits so x - step never wraps.
    function automatic logic [10:0] slew(input logic [10:0] x,
                                         input logic [10:0] s);
        logic [11:0] xe;
        logic [11:0] se;
        logic [11:0] st;
        xe = {1'b0, x};
        se = {1'b0, s};
        st = 12'(MAX_STEP);
        if (xe + st < se) begin
            return 11'(xe + st);
        end else if (se + st < xe) begin
            return 11'(xe - st);
        end else begin
            return s;
        end
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_RUN;
            S_RUN:    state_d = wrap ? S_COMMIT : S_RUN;
            S_COMMIT: state_d = S_RUN;
            default:  state_d = S_RESET;
        endcase
    end

    always_comb begin
        tick      = (presc_q == PW'(TICK_DIV - 1));
        wrap      = tick && (cntr_q == 12'(PERIOD - 1));
        // Ready drops only in the wrap cycle so the commit sees stable shadows.
        upd_ready = !rst && !wrap;
        xfer      = upd_valid && upd_ready;
        raw_sat   = (upd_data > 10'(RAW_MAX)) ? 10'(RAW_MAX) : upd_data;
        tgt       = 11'(raw_sat) + 11'(X_OFFSET);
        tocnt_inc = (tocnt_q == TW'(TIMEOUT_FRAMES)) ? tocnt_q
                                                    : tocnt_q + 1'b1;

        presc_d = tick ? '0 : presc_q + 1'b1;
        cntr_d  = cntr_q;
        xl_d    = xl_q;
        xr_d    = xr_q;
        shl_d   = shl_q;
        shr_d   = shr_q;
        fs_d    = wrap;
        to_d    = to_q;
        tocnt_d = tocnt_q;
        fresh_d = fresh_q;
        tl      = shl_q;
        tr      = shr_q;

        if (tick) begin
            cntr_d = wrap ? 12'd0 : cntr_q + 12'd1;
        end

        if (xfer) begin
            if (upd_ch) begin
                shr_d = tgt;
            end else begin
                shl_d = tgt;
            end
            fresh_d = 1'b1;
            to_d    = 1'b0;
        end

        if (wrap) begin
            if (fresh_q) begin
                tocnt_d = '0;
                fresh_d = 1'b0;
            end else begin
                tocnt_d = tocnt_inc;
                // Fallback target applies from the commit that trips it.
                if (to_q || tocnt_inc == TW'(TIMEOUT_FRAMES)) begin
                    to_d  = 1'b1;
                    shl_d = 11'(NEUTRAL);
                    shr_d = 11'(NEUTRAL);
                    tl    = 11'(NEUTRAL);
                    tr    = 11'(NEUTRAL);
                end
            end
            xl_d = slew(xl_q, tl);
            xr_d = slew(xr_q, tr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
            presc_q <= '0;
            cntr_q  <= '0;
            xl_q    <= 11'(NEUTRAL);
            xr_q    <= 11'(NEUTRAL);
            shl_q   <= 11'(NEUTRAL);
            shr_q   <= 11'(NEUTRAL);
            fs_q    <= 1'b0;
            to_q    <= 1'b0;
            tocnt_q <= '0;
            fresh_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cntr_q  <= cntr_d;
            xl_q    <= xl_d;
            xr_q    <= xr_d;
            shl_q   <= shl_d;
            shr_q   <= shr_d;
            fs_q    <= fs_d;
            to_q    <= to_d;
            tocnt_q <= tocnt_d;
            fresh_q <= fresh_d;
        end
    end

    assign cntr_val    = cntr_q;
    assign x_left      = xl_q;
    assign x_right     = xr_q;
    assign frame_start = fs_q;
    assign timeout     = to_q;

endmodule

// File: tb/tb_servo_frame_sched.sv
// Bench for servo_frame_sched: long-frame instance (PERIOD 3000) for
// counter/handshake/reset, short-frame instance for slew and timeout.
module tb_servo_frame_sched;

    typedef struct packed {
        logic [10:0] l;
        logic [10:0] r;
        logic        t;
    } exp_t;

    logic        clk;
    logic        rst [2];
    logic        vld [2];
    logic        rdy [2];
    logic        ch  [2];
    logic [9:0]  dat [2];
    logic [11:0] cnt [2];
    logic [10:0] xl  [2];
    logic [10:0] xr  [2];
    logic        fs  [2];
    logic        to  [2];

    int n_chk;
    int n_fail;
    exp_t q0[$];
    exp_t q1[$];

    servo_frame_sched #(
        .TICK_DIV(2), .PERIOD(3000), .TIMEOUT_FRAMES(100)
    ) dut0 (
        .clk(clk), .rst(rst[0]), .upd_valid(vld[0]), .upd_ready(rdy[0]),
        .upd_ch(ch[0]), .upd_data(dat[0]), .cntr_val(cnt[0]),
        .x_left(xl[0]), .x_right(xr[0]), .frame_start(fs[0]),
        .timeout(to[0])
    );

    servo_frame_sched #(
        .TICK_DIV(2), .PERIOD(16), .TIMEOUT_FRAMES(3)
    ) dut1 (
        .clk(clk), .rst(rst[1]), .upd_valid(vld[1]), .upd_ready(rdy[1]),
        .upd_ch(ch[1]), .upd_data(dat[1]), .cntr_val(cnt[1]),
        .x_left(xl[1]), .x_right(xr[1]), .frame_start(fs[1]),
        .timeout(to[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input int l, input int r, input int t);
        exp_t e;
        e.l = 11'(l);
        e.r = 11'(r);
        e.t = 1'(t);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic pop_cmp(input int d, input bit do_cmp);
        exp_t e;
        int   sz;
        sz = (d == 0) ? q0.size() : q1.size();
        chk($sformatf("sb%0d_nonempty", d), 32'(sz != 0), 1);
        if (sz != 0) begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            if (do_cmp) begin
                chk($sformatf("d%0d_x_left", d), 32'(xl[d]), 32'(e.l));
                chk($sformatf("d%0d_x_right", d), 32'(xr[d]), 32'(e.r));
                chk($sformatf("d%0d_timeout", d), 32'(to[d]), 32'(e.t));
                chk($sformatf("d%0d_cntr_at_fs", d), 32'(cnt[d]), 0);
            end
        end
    endtask

    task automatic wait_fs(input int d, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fs[d]) begin
                seen = 1'b1;
                break;
            end
        end
        chk($sformatf("d%0d_frame_start_seen", d), 32'(seen), 1);
        pop_cmp(d, seen);
    endtask

    task automatic wait_cnt(input int d, input int v, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cnt[d] == 12'(v)) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("d%0d_reach_cntr_%0d", d, v), 32'(seen), 1);
    endtask

    task automatic send(input int d, input int c, input int v);
        bit acc;
        acc    = 1'b0;
        vld[d] = 1'b1;
        ch[d]  = 1'(c);
        dat[d] = 10'(v);
        for (int i = 0; i < 8; i++) begin
            acc = rdy[d];
            @(negedge clk);
            if (acc) break;
        end
        vld[d] = 1'b0;
        chk($sformatf("d%0d_send_accepted", d), 32'(acc), 1);
    endtask

    initial begin
        int bad;
        n_chk  = 0;
        n_fail = 0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            vld[d] = 1'b0;
            ch[d]  = 1'b0;
            dat[d] = '0;
        end
        repeat (3) @(negedge clk);

        chk("rst_cntr", 32'(cnt[0]), 0);
        chk("rst_x_left", 32'(xl[0]), 1500);
        chk("rst_x_right", 32'(xr[0]), 1500);
        chk("rst_frame_start", 32'(fs[0]), 0);
        chk("rst_timeout", 32'(to[0]), 0);
        chk("rst_ready", 32'(rdy[0]), 0);

        // Free run: 2 cycles per tick, wrap after 6000 cycles.
        rst[0] = 1'b0;
        @(negedge clk);
        chk("run_cntr_e1", 32'(cnt[0]), 0);
        chk("run_ready", 32'(rdy[0]), 1);
        @(negedge clk);
        chk("run_cntr_e2", 32'(cnt[0]), 1);
        bad = 0;
        for (int i = 0; i < 5997; i++) begin
            @(negedge clk);
            if (xl[0] != 11'd1500 || xr[0] != 11'd1500 || fs[0]) bad++;
        end
        chk("free_outputs_stable", 32'(bad), 0);
        chk("wrap_cycle_cntr", 32'(cnt[0]), 2999);
        chk("wrap_cycle_ready_low", 32'(rdy[0]), 0);
        @(negedge clk);
        chk("wrap_frame_start", 32'(fs[0]), 1);
        chk("wrap_cntr_zero", 32'(cnt[0]), 0);
        chk("wrap_ready_back", 32'(rdy[0]), 1);
        chk("wrap_x_left", 32'(xl[0]), 1500);
        chk("wrap_x_right", 32'(xr[0]), 1500);
        @(negedge clk);
        chk("frame_start_one_cycle", 32'(fs[0]), 0);

        // Clamp and last-wins.
        send(0, 1, 1023);
        send(0, 1, 520);
        push(0, 1500, 1520, 0);
        wait_fs(0, 7000);
        send(0, 1, 1023);
        chk("no_midframe_change", 32'(xr[0]), 1520);
        push(0, 1500, 1570, 0);
        wait_fs(0, 7000);

        // Boundary collision: valid held through the wrap cycle.
        wait_cnt(0, 2999, 7000);
        @(negedge clk);
        vld[0] = 1'b1;
        ch[0]  = 1'b0;
        dat[0] = 10'd300;
        chk("collide_ready_low", 32'(rdy[0]), 0);
        push(0, 1500, 1620, 0);
        @(negedge clk);
        chk("collide_frame_start", 32'(fs[0]), 1);
        pop_cmp(0, 1'b1);
        chk("collide_ready_high", 32'(rdy[0]), 1);
        @(negedge clk);
        vld[0] = 1'b0;
        push(0, 1450, 1670, 0);
        wait_fs(0, 7000);

        // Reset mid-frame with a pending shadow.
        send(0, 1, 0);
        wait_cnt(0, 1234, 7000);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("midrst_cntr", 32'(cnt[0]), 0);
        chk("midrst_x_left", 32'(xl[0]), 1500);
        chk("midrst_x_right", 32'(xr[0]), 1500);
        chk("midrst_frame_start", 32'(fs[0]), 0);
        chk("midrst_timeout", 32'(to[0]), 0);
        chk("midrst_ready", 32'(rdy[0]), 0);
        rst[0] = 1'b0;
        push(0, 1500, 1500, 0);
        wait_fs(0, 7000);

        // Slew on the short-frame instance, refreshed every frame.
        rst[1] = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 10; i++) begin
            send(1, 0, 1000);
            if (i > 1) begin
                chk("slew_midframe_hold", 32'(xl[1]), 32'(1500 + 50 * (i - 1)));
            end
            push(1, 1500 + 50 * i, 1500, 0);
            wait_fs(1, 100);
        end

        // Timeout: two quiet frames, then neutral forced and ramp down.
        push(1, 2000, 1500, 0);
        wait_fs(1, 100);
        push(1, 2000, 1500, 0);
        wait_fs(1, 100);
        push(1, 1950, 1500, 1);
        wait_fs(1, 100);
        for (int k = 1; k <= 10; k++) begin
            push(1, (1950 - 50 * k < 1500) ? 1500 : 1950 - 50 * k, 1500, 1);
            wait_fs(1, 100);
        end
        send(1, 0, 200);
        chk("timeout_cleared", 32'(to[1]), 0);
        push(1, 1450, 1500, 0);
        wait_fs(1, 100);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
